ctx_stack_seq: RTL and testbench

CTX_STACK_SEQ -- requirements
Module: ctx_stack_seq

---
 rtl/ctx_stack_seq.sv | 150 +++++++++++++++
 tb/tb_ctx_stack_seq.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ctx_stack_seq.sv
// ctx_stack_seq: moves registers between a small register file and a CPU
// hardware stack. A save pushes r0..rN-1 in ascending order; a restore pops
// them back in descending order. The stack samples its strobes on the falling
// edge, so popped data is written back to the register file one cycle after
// each pop. A final WB state carries out the last of those writes.
module ctx_stack_seq #(
  parameter int DEPTH = 1024,
  parameter int NREG  = 16
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         start_save_i,
  input  logic                         start_restore_i,
  input  logic [4:0]                   count_i,
  output logic [$clog2(NREG)-1:0]      reg_raddr_o,
  input  logic [31:0]                  reg_rdata_i,
  output logic                         reg_we_o,
  output logic [$clog2(NREG)-1:0]      reg_waddr_o,
  output logic [31:0]                  reg_wdata_o,
  output logic                         stk_push_o,
  output logic                         stk_pop_o,
  output logic [31:0]                  stk_d_o,
  input  logic [31:0]                  stk_q_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         err_o,
  output logic [$clog2(DEPTH+1)-1:0]   depth_o
);

  localparam int AW = $clog2(NREG);
  localparam int DW = $clog2(DEPTH + 1);
  localparam logic [DW:0] DEPTH_C = (DW+1)'(DEPTH);
  localparam logic [4:0]  NREG_C  = 5'(NREG);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SAVE    = 2'd1,
    S_RESTORE = 2'd2,
    S_WB      = 2'd3
  } state_e;

  state_e          state_q;
  logic [AW-1:0]   idx_q;
  logic [4:0]      rem_q;
  logic [DW-1:0]   depth_q;
  logic            done_q;
  logic            err_q;
  logic            wb_vld_q;
  logic [AW-1:0]   wb_addr_q;

  // Admission arithmetic is done one bit wider than depth so the sum with
  // count cannot wrap and hide an overflow.
  logic [DW:0] cnt_ext;
  logic [DW:0] depth_ext;
  logic [DW:0] depth_sum;
  logic        save_bad;
  logic        restore_bad;

  assign cnt_ext     = {{(DW-4){1'b0}}, count_i};
  assign depth_ext   = {1'b0, depth_q};
  assign depth_sum   = depth_ext + cnt_ext;
  assign save_bad    = (count_i > NREG_C) || (depth_sum > DEPTH_C);
  assign restore_bad = (count_i > NREG_C) || (cnt_ext > depth_ext);

  // Sequencer: admission, idx/remaining stepping, occupancy and status pulses.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      rem_q     <= '0;
      depth_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      wb_vld_q  <= 1'b0;
      wb_addr_q <= '0;
    end else begin
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      wb_vld_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // Save has priority over a simultaneous restore.
          if (start_save_i) begin
            if (save_bad) begin
              err_q <= 1'b1;
            end else if (count_i == 5'd0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= S_SAVE;
              idx_q   <= '0;
              rem_q   <= count_i;
            end
          end else if (start_restore_i) begin
            if (restore_bad) begin
              err_q <= 1'b1;
            end else if (count_i == 5'd0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= S_RESTORE;
              idx_q   <= AW'(count_i - 5'd1);
              rem_q   <= count_i;
            end
          end
        end
        S_SAVE: begin
          depth_q <= depth_q + 1'b1;
          idx_q   <= idx_q + 1'b1;
          rem_q   <= rem_q - 1'b1;
          if (rem_q == 5'd1) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            done_q  <= 1'b1;
          end
        end
        S_RESTORE: begin
          // Remember which register this pop belongs to; the data arrives
          // on the falling edge and is written during the next cycle.
          depth_q   <= depth_q - 1'b1;
          wb_vld_q  <= 1'b1;
          wb_addr_q <= idx_q;
          idx_q     <= idx_q - 1'b1;
          rem_q     <= rem_q - 1'b1;
          if (rem_q == 5'd1) begin
            state_q <= S_WB;
            idx_q   <= '0;
          end
        end
        S_WB: begin
          state_q <= S_IDLE;
          done_q  <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Strobes and data paths decode directly from the state register.
  assign stk_push_o  = (state_q == S_SAVE);
  assign stk_pop_o   = (state_q == S_RESTORE);
  assign reg_raddr_o = stk_push_o ? idx_q : '0;
  assign stk_d_o     = stk_push_o ? reg_rdata_i : '0;
  assign reg_we_o    = wb_vld_q;
  assign reg_waddr_o = wb_addr_q;
  assign reg_wdata_o = wb_vld_q ? stk_q_i : '0;
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign depth_o     = depth_q;

endmodule

// File: tb/tb_ctx_stack_seq.sv
// Bench for ctx_stack_seq: falling-edge stack model, register-file model,
// table of single operations plus hand sequences for data order, overflow,
// reset abort and back-to-back starts.
module tb_ctx_stack_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_save, start_restore;
  logic [4:0]  count;
  logic [3:0]  reg_raddr, reg_waddr;
  logic [31:0] reg_rdata, reg_wdata, stk_d, stk_q;
  logic        reg_we, stk_push, stk_pop, busy, done, err;
  logic [10:0] depth;

  always #5 clk = ~clk;

  ctx_stack_seq #(.DEPTH(1024), .NREG(16)) dut (
    .clk_i(clk), .reset_i(reset),
    .start_save_i(start_save), .start_restore_i(start_restore), .count_i(count),
    .reg_raddr_o(reg_raddr), .reg_rdata_i(reg_rdata),
    .reg_we_o(reg_we), .reg_waddr_o(reg_waddr), .reg_wdata_o(reg_wdata),
    .stk_push_o(stk_push), .stk_pop_o(stk_pop), .stk_d_o(stk_d), .stk_q_i(stk_q),
    .busy_o(busy), .done_o(done), .err_o(err), .depth_o(depth)
  );

  // Register file and stack models, both acting on the falling edge.
  logic [31:0] rf [0:15];
  logic [31:0] rf_init [0:15];
  logic        load_rf = 1'b0;
  logic [31:0] smem [0:1023];
  int          sp = 0;

  assign reg_rdata = rf[reg_raddr];

  always @(negedge clk) begin
    if (load_rf) begin
      for (int i = 0; i < 16; i++) rf[i] <= rf_init[i];
    end else if (reg_we) begin
      rf[reg_waddr] <= reg_wdata;
    end
    if (!reset) begin
      sp <= 0;
    end else if (stk_push) begin
      smem[sp] <= stk_d;
      sp <= sp + 1;
    end else if (stk_pop) begin
      stk_q <= smem[sp-1];
      sp <= sp - 1;
    end
  end

  // Strobe counters, write log and invariant watch.
  int n_push = 0, n_pop = 0, n_we = 0, n_done = 0, inv_err = 0;
  logic [3:0] wlog [$];

  always @(posedge clk) begin
    if (stk_push) n_push <= n_push + 1;
    if (stk_pop)  n_pop  <= n_pop + 1;
    if (reg_we) begin
      n_we <= n_we + 1;
      wlog.push_back(reg_waddr);
    end
    if (done) n_done <= n_done + 1;
    if (reset && ((stk_push && stk_pop) || (stk_push && reg_we) || depth > 11'd1024)) begin
      inv_err <= inv_err + 1;
      $display("FAIL invariant push=%0b pop=%0b we=%0b depth=%0d", stk_push, stk_pop, reg_we, depth);
    end
  end

  int checks = 0, errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Result of the last run_op.
  int o_err, o_push, o_pop, o_we, o_lat;

  // Issue one request from a point just after a rising edge, then wait for
  // done or err (bounded).
  task automatic run_op(input logic s, input logic r, input logic [4:0] c);
    int p0, q0, w0;
    p0 = n_push; q0 = n_pop; w0 = n_we;
    start_save = s; start_restore = r; count = c;
    @(posedge clk); #1;
    start_save = 1'b0; start_restore = 1'b0;
    o_lat = 0;
    while (!(done || err) && o_lat < 40) begin
      @(posedge clk); #1;
      o_lat++;
    end
    o_err  = int'(err);
    o_push = n_push - p0;
    o_pop  = n_pop - q0;
    o_we   = n_we - w0;
  endtask

  task automatic load_regs(input logic [31:0] base, input int n);
    for (int i = 0; i < 16; i++) rf_init[i] = (i < n) ? base + 32'(i) : 32'h0;
    @(negedge clk); load_rf = 1'b1;
    @(negedge clk); #1 load_rf = 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic       s;
    logic       r;
    logic [4:0] c;
    int         e_err;
    int         e_push;
    int         e_pop;
    int         e_we;
    int         e_lat;
    int         e_depth;
  } vec_t;

  vec_t vt [11];

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int d0;
    // Starts from depth 0.
    vt[0]  = '{1'b1, 1'b0, 5'd0,  0, 0, 0, 0, 0, 0};
    vt[1]  = '{1'b1, 1'b0, 5'd17, 1, 0, 0, 0, 0, 0};
    vt[2]  = '{1'b0, 1'b1, 5'd1,  1, 0, 0, 0, 0, 0};
    vt[3]  = '{1'b1, 1'b0, 5'd3,  0, 3, 0, 0, 3, 3};
    vt[4]  = '{1'b0, 1'b1, 5'd17, 1, 0, 0, 0, 0, 3};
    vt[5]  = '{1'b1, 1'b1, 5'd1,  0, 1, 0, 0, 1, 4};
    vt[6]  = '{1'b0, 1'b1, 5'd4,  0, 0, 4, 4, 5, 0};
    vt[7]  = '{1'b0, 1'b1, 5'd0,  0, 0, 0, 0, 0, 0};
    vt[8]  = '{1'b1, 1'b0, 5'd2,  0, 2, 0, 0, 2, 2};
    vt[9]  = '{1'b0, 1'b1, 5'd3,  1, 0, 0, 0, 0, 2};
    vt[10] = '{1'b0, 1'b1, 5'd2,  0, 0, 2, 2, 3, 0};

    reset = 1'b0; start_save = 1'b0; start_restore = 1'b0; count = '0;
    for (int i = 0; i < 16; i++) rf_init[i] = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", int'({busy, done, err, stk_push, stk_pop, reg_we, depth}), 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Save r0..r3 then restore into cleared registers.
    load_regs(32'hA0, 4);
    run_op(1'b1, 1'b0, 5'd4);
    chk("saveA_push", o_push, 4);
    chk("saveA_lat", o_lat, 4);
    chk("saveA_depth", int'(depth), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("saveA_stk%0d", i), int'(smem[i]), 32'hA0 + i);
    load_regs(32'h0, 0);
    wlog.delete();
    run_op(1'b0, 1'b1, 5'd4);
    chk("restA_we", o_we, 4);
    chk("restA_depth", int'(depth), 0);
    chk("restA_first_addr", int'(wlog[0]), 3);
    chk("restA_last_addr", int'(wlog[3]), 0);
    for (int i = 0; i < 4; i++) chk($sformatf("restA_r%0d", i), int'(rf[i]), 32'hA0 + i);

    // Table of single operations.
    for (int k = 0; k < 11; k++) begin
      run_op(vt[k].s, vt[k].r, vt[k].c);
      chk($sformatf("v%0d_err", k), o_err, vt[k].e_err);
      chk($sformatf("v%0d_push", k), o_push, vt[k].e_push);
      chk($sformatf("v%0d_pop", k), o_pop, vt[k].e_pop);
      chk($sformatf("v%0d_we", k), o_we, vt[k].e_we);
      chk($sformatf("v%0d_lat", k), o_lat, vt[k].e_lat);
      chk($sformatf("v%0d_depth", k), int'(depth), vt[k].e_depth);
    end

    // Fill to 1020, then probe the top of the stack.
    for (int k = 0; k < 63; k++) run_op(1'b1, 1'b0, 5'd16);
    run_op(1'b1, 1'b0, 5'd12);
    chk("fill_depth", int'(depth), 1020);
    run_op(1'b1, 1'b0, 5'd5);
    chk("ovf5_err", o_err, 1);
    chk("ovf5_push", o_push, 0);
    chk("ovf5_depth", int'(depth), 1020);
    run_op(1'b1, 1'b0, 5'd4);
    chk("full4_err", o_err, 0);
    chk("full4_depth", int'(depth), 1024);
    run_op(1'b1, 1'b0, 5'd1);
    chk("full1_err", o_err, 1);
    chk("full1_depth", int'(depth), 1024);

    // Reset clears occupancy.
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    chk("rst_depth", int'(depth), 0);

    // Reset during the third cycle of a count=8 save.
    start_save = 1'b1; count = 5'd8;
    @(posedge clk); #1;
    start_save = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    d0 = n_done;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("abort_strobes", int'({stk_push, stk_pop, reg_we}), 0);
    chk("abort_depth", int'(depth), 0);
    chk("abort_busy", int'(busy), 0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_done", n_done - d0, 0);
    chk("abort_stack_sp", sp, 0);

    // Back-to-back: next start issued in the done cycle.
    run_op(1'b1, 1'b0, 5'd1);
    chk("b2b_done_high", int'(done), 1);
    run_op(1'b1, 1'b0, 5'd2);
    chk("b2b_lat", o_lat, 2);
    chk("b2b_push", o_push, 2);
    chk("b2b_depth", int'(depth), 3);

    @(posedge clk); #1;
    chk("invariants", inv_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
